oven_key_conditioner: RTL
=========================

# oven_key_conditioner

Input-side front end for the oven controller. It takes the raw active-low UP/DOWN push buttons, synchronizes and debounces them, and emits clean single-cycle press pulses with optional hold-to-repeat. The oven FSM then consumes one-cycle increment/decrement events on `clk` instead of sampling raw levels on a divided clock. It sits between the board KEY pins and the timer/preheat adjust logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable `clk` cycles required to accept a press or release (≥2).
- `REPEAT_DELAY`, 25000000: cycles from accepted press to the first repeat pulse.
- `REPEAT_PERIOD`, 6250000: cycles between subsequent repeat pulses.

Ports:
- `clk`, in, 1: system clock; the only clock in the block.
- `rst`, in, 1: reset, synchronous and active-high.
- `UP`, in, 1: raw button, active low (0 = pressed), asynchronous.
- `DOWN`, in, 1: raw button, active low, asynchronous.
- `up_pulse`, out, 1: one-cycle pulse per accepted UP press or repeat.
- `down_pulse`, out, 1: one-cycle pulse per accepted DOWN press or repeat.
- `up_held`, out, 1: debounced UP level (1 = pressed).
- `down_held`, out, 1: debounced DOWN level.

## Operation
- Each button goes through a 2-flop synchronizer. The flops reset to 1 (released). Pressed level `p = ~sync2`.
- Per-channel FSM with states IDLE, DB_PRESS, PRESSED, DB_RELEASE. Each channel has a debounce counter `dcnt` and a repeat counter `rcnt`, each `$clog2` sized to its maximum parameter.
- IDLE: if `p`, go to DB_PRESS and set `dcnt` = 0.
- DB_PRESS: if `!p`, go to IDLE (the glitch is rejected with no output). Otherwise `dcnt`++. When `dcnt == DEBOUNCE_CYCLES-1`, go to PRESSED, set `held` = 1, raise the raw press event, and set `rcnt` = 0.
- PRESSED: if `!p`, go to DB_RELEASE and set `dcnt` = 0. Otherwise `rcnt`++. Repeat events fire when `rcnt` reaches `REPEAT_DELAY-1`, then every `REPEAT_PERIOD` cycles after that (the counter reloads on each repeat).
- DB_RELEASE: if `p`, return to PRESSED. `held` stays 1, `rcnt` keeps its value, and no new press event is raised. Otherwise `dcnt`++. When `dcnt == DEBOUNCE_CYCLES-1`, go to IDLE and set `held` = 0.
- Mutual exclusion (UP wins):
  - `down_pulse` = DOWN event AND NOT `up_held` (registered `up_held`, prior cycle).
  - If both channels raise an event in the same cycle, only `up_pulse` fires.
  - The DOWN FSM itself is not blocked; only its pulses are masked.
- `up_held` and `down_held` can both be 1 at the same time.
- Counters saturate only at their compare values, so wrap-around is impossible by construction.

## Timing
- Reset (`rst` = 1 at a `clk` edge):
  - Synchronizers go to 1.
  - FSMs go to IDLE; `dcnt` and `rcnt` go to 0.
  - All four outputs are 0 on the next cycle.
- Reset asserted mid-press discards the press. After release of `rst`, a button that is still held is re-debounced from IDLE.
- Press latency: a clean input edge at cycle 0 produces the registered pulse at cycle 2 (sync) + `DEBOUNCE_CYCLES` + 1.
- `held` rises in the same cycle as the first pulse.
- Release latency: `held` falls 2 + `DEBOUNCE_CYCLES` + 1 cycles after a clean release edge.
- All outputs are registered; the pulse width is exactly 1 cycle.
- A hold of N cycles past acceptance yields 1 + repeats. Repeats occur at offsets `REPEAT_DELAY`, `REPEAT_DELAY+REPEAT_PERIOD`, … from the first pulse.

## Configuration
- `OVEN_KEY_AUTO_REPEAT_EN`
- Defined: PRESSED-state repeat logic and `rcnt` are present, as described above.
- Undefined: `rcnt` and the repeat comparators are removed. Exactly one pulse is produced per accepted press regardless of hold length. The REPEAT parameters are ignored. All other behaviour is identical.

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Reset then idle: `UP`=`DOWN`=1, hold `rst` 2 cycles -> all outputs 0. Assert `rst` while UP has been held 3 cycles -> outputs 0; after release of `rst`, the first `up_pulse` comes 7 cycles later.
- Clean press: `UP`→0 at cycle 0 and held 8 cycles -> single `up_pulse` at cycle 7; `up_held`=1 from cycle 7.
- Glitch rejection: `UP` low for 3 cycles then high -> no `up_pulse`, and `up_held` stays 0. Release bounce (1 cycle high during hold) -> `up_held` stays 1 with no extra pulse.
- Auto-repeat (macro defined): hold `DOWN` low 30 cycles from acceptance -> `down_pulse` at +0, +10, +13, +16, +19, +22, +25, +28. With the macro undefined -> a single pulse at +0.
- Simultaneous: `UP` and `DOWN` driven low on the same cycle -> only `up_pulse` at cycle 7, with `up_held`=`down_held`=1. `down_pulse` stays 0 until UP is released and debounced.
- Release timing: release `UP` after acceptance -> `up_held` falls exactly 7 cycles after the edge.

Source files
------------

// File: rtl/oven_key_conditioner.sv
// oven_key_conditioner
//   Conditions the raw active-low UP/DOWN push buttons for the oven controller:
//   2-flop synchronizer, per-button debounce FSM, single-cycle press pulses and
//   optional hold-to-repeat. UP has priority: DOWN pulses are masked while UP is held.
//
// Build option:
//   OVEN_KEY_AUTO_REPEAT_EN  defined   -> hold-to-repeat pulses after REPEAT_DELAY,
//                                        then every REPEAT_PERIOD cycles
//                            undefined -> exactly one pulse per accepted press
//
// Ports:
//   clk         in   system clock (only clock)
//   rst         in   synchronous, active-high reset
//   UP, DOWN    in   raw buttons, active low, asynchronous
//   up_pulse    out  one-cycle pulse per accepted UP press/repeat
//   down_pulse  out  one-cycle pulse per accepted DOWN press/repeat (masked by UP)
//   up_held     out  debounced UP level (1 = pressed)
//   down_held   out  debounced DOWN level (1 = pressed)
module oven_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 6250000
) (
  input  logic clk,
  input  logic rst,
  input  logic UP,
  input  logic DOWN,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_held,
  output logic down_held
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam int unsigned    DCW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);

`ifdef OVEN_KEY_AUTO_REPEAT_EN
  localparam int unsigned    RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned    RCW     = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);
`else
  // Repeat timing is compiled out; the parameters remain only so overrides still bind.
  if ((REPEAT_DELAY == 0) && (REPEAT_PERIOD == 0)) begin : g_repeat_unused
  end
`endif

  // Bit 0 = UP channel, bit 1 = DOWN channel.
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_press;
  logic [1:0] w_evt;
  logic [1:0] w_held;

  logic r_up_pulse;
  logic r_down_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {DOWN, UP};
      r_sync2 <= r_sync1;
    end
  end

  assign w_press = ~r_sync2;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t         r_state;
    state_t         w_state_nxt;
    logic [DCW-1:0] r_dcnt;
    logic [DCW-1:0] w_dcnt_nxt;
    logic           r_held;
    logic           w_held_nxt;
    logic           w_evt_ch;
`ifdef OVEN_KEY_AUTO_REPEAT_EN
    logic [RCW-1:0] r_rcnt;
    logic [RCW-1:0] w_rcnt_nxt;
    logic           r_rep;      // 0: waiting for the first repeat, 1: periodic phase
    logic           w_rep_nxt;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= IDLE;
        r_dcnt  <= '0;
        r_held  <= 1'b0;
`ifdef OVEN_KEY_AUTO_REPEAT_EN
        r_rcnt  <= '0;
        r_rep   <= 1'b0;
`endif
      end else begin
        r_state <= w_state_nxt;
        r_dcnt  <= w_dcnt_nxt;
        r_held  <= w_held_nxt;
`ifdef OVEN_KEY_AUTO_REPEAT_EN
        r_rcnt  <= w_rcnt_nxt;
        r_rep   <= w_rep_nxt;
`endif
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_held_nxt  = r_held;
      w_evt_ch    = 1'b0;
`ifdef OVEN_KEY_AUTO_REPEAT_EN
      w_rcnt_nxt  = r_rcnt;
      w_rep_nxt   = r_rep;
`endif
      case (r_state)
        IDLE: begin
          if (w_press[ch]) begin
            w_state_nxt = DB_PRESS;
            w_dcnt_nxt  = '0;
          end
        end
        DB_PRESS: begin
          if (!w_press[ch]) begin
            w_state_nxt = IDLE;
          end else if (r_dcnt == DC_LAST) begin
            w_state_nxt = PRESSED;
            w_held_nxt  = 1'b1;
            w_evt_ch    = 1'b1;
`ifdef OVEN_KEY_AUTO_REPEAT_EN
            w_rcnt_nxt  = '0;
            w_rep_nxt   = 1'b0;
`endif
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_press[ch]) begin
            w_state_nxt = DB_RELEASE;
            w_dcnt_nxt  = '0;
          end
`ifdef OVEN_KEY_AUTO_REPEAT_EN
          else if (r_rcnt == (r_rep ? RP_LAST : RD_LAST)) begin
            w_evt_ch   = 1'b1;
            w_rcnt_nxt = '0;
            w_rep_nxt  = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
`endif
        end
        DB_RELEASE: begin
          // A bounce back to pressed resumes the hold; rcnt is left untouched.
          if (w_press[ch]) begin
            w_state_nxt = PRESSED;
          end else if (r_dcnt == DC_LAST) begin
            w_state_nxt = IDLE;
            w_held_nxt  = 1'b0;
          end else begin
            w_dcnt_nxt = r_dcnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    assign w_evt[ch]  = w_evt_ch;
    assign w_held[ch] = r_held;
  end

  // DOWN is masked by the registered UP level and by a same-cycle UP event,
  // since both channels can accept on the same edge before up_held is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_pulse   <= 1'b0;
      r_down_pulse <= 1'b0;
    end else begin
      r_up_pulse   <= w_evt[0];
      r_down_pulse <= w_evt[1] & ~w_evt[0] & ~w_held[0];
    end
  end

  assign up_pulse   = r_up_pulse;
  assign down_pulse = r_down_pulse;
  assign up_held    = w_held[0];
  assign down_held  = w_held[1];

endmodule
